// File: rtl/ca_pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: default register
// address width, the sequencer state type and the hazard-length encoding.
package ca_pipe_pkg;

   localparam int REG_AW_DEF = 5;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } stall_state_t;

   typedef logic [1:0] hz_len_t;

   localparam hz_len_t HZ_NONE = 2'd0;
   localparam hz_len_t HZ_ONE  = 2'd1;
   localparam hz_len_t HZ_TWO  = 2'd2;

endpackage : ca_pipe_pkg

// File: rtl/hazard_len_calc.sv
// Hazard length calculator: compares the ID-stage source registers against the
// destinations in ID/EX and EX/MEM and encodes how many stall cycles the
// instruction in ID needs. Register $zero never matches; Rt only counts when
// the instruction actually reads it.
module hazard_len_calc
   import ca_pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              id_is_branch,
   input  logic              ex_memread,
   input  logic              ex_regwrite,
   input  logic [REG_AW-1:0] ex_wreg,
   input  logic              mem_memread,
   input  logic [REG_AW-1:0] mem_wreg,
   output hz_len_t           hz_len
);

   logic match_ex_s;
   logic match_mem_s;

   // A source matches a destination only when equal and not $zero.
   function automatic logic reg_match(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dst);
      return (src == dst) && (src != {REG_AW{1'b0}});
   endfunction

   // Source/destination matching against the EX and MEM destinations.
   always_comb begin
      match_ex_s  = 1'b0;
      match_mem_s = 1'b0;
      match_ex_s  = reg_match(id_rs, ex_wreg) ||
                    (id_uses_rt && reg_match(id_rt, ex_wreg));
      match_mem_s = reg_match(id_rs, mem_wreg) ||
                    (id_uses_rt && reg_match(id_rt, mem_wreg));
   end

   // Encode the stall length; a branch waiting on a load in EX needs two cycles.
   always_comb begin
      hz_len = HZ_NONE;
      if (id_is_branch && ex_memread && match_ex_s) begin
         hz_len = HZ_TWO;
      end else if (!id_is_branch && ex_memread && match_ex_s) begin
         hz_len = HZ_ONE;
      end else if (id_is_branch && ex_regwrite && !ex_memread && match_ex_s) begin
         hz_len = HZ_ONE;
      end else if (id_is_branch && mem_memread && match_mem_s) begin
         hz_len = HZ_ONE;
      end else begin
         hz_len = HZ_NONE;
      end
   end

endmodule : hazard_len_calc

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline, sitting beside ID.
// Freezes PC and IF/ID, inserts ID/EX bubbles for load-use and branch-operand
// hazards, flushes IF/ID on taken branches and jumps, and freezes the whole
// front end while memory is not ready. A two-cycle stall is latched at
// detection time (IDLE -> HOLD) and is not re-evaluated while held.
// Optional build macro: STALL_STATS_EN adds saturating stall/flush counters;
// without it stall_cycles and flush_count are tied to zero.
module pipeline_stall_ctrl
   import ca_pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              id_is_branch,
   input  logic              id_is_jump,
   input  logic              branch_taken,
   input  logic              ex_memread,
   input  logic              ex_regwrite,
   input  logic [REG_AW-1:0] ex_wreg,
   input  logic              mem_memread,
   input  logic [REG_AW-1:0] mem_wreg,
   input  logic              mem_wait,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_write,
   output logic              idex_noop,
   output logic              ifid_flush,
   output logic [STAT_W-1:0] stall_cycles,
   output logic [STAT_W-1:0] flush_count
);

   stall_state_t state_r;
   hz_len_t      hz_len_s;
   logic         stall_s;
   logic         flush_s;

   hazard_len_calc #(
      .REG_AW (REG_AW)
   ) u_hazard_len_calc (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .id_is_branch (id_is_branch),
      .ex_memread   (ex_memread),
      .ex_regwrite  (ex_regwrite),
      .ex_wreg      (ex_wreg),
      .mem_memread  (mem_memread),
      .mem_wreg     (mem_wreg),
      .hz_len       (hz_len_s)
   );

   // Classify the current cycle; memory wait masks both stall and flush.
   always_comb begin
      stall_s = 1'b0;
      flush_s = 1'b0;
      if (mem_wait) begin
         stall_s = 1'b0;
         flush_s = 1'b0;
      end else if (state_r == HOLD) begin
         stall_s = 1'b1;
      end else if (hz_len_s != HZ_NONE) begin
         stall_s = 1'b1;
      end else begin
         flush_s = id_is_jump || (id_is_branch && branch_taken);
      end
   end

   // Stall sequencer: enter HOLD only for a two-cycle hazard; frozen during memory wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else if (mem_wait) begin
         state_r <= state_r;
      end else begin
         case (state_r)
            IDLE:    state_r <= (hz_len_s == HZ_TWO) ? HOLD : IDLE;
            HOLD:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Output decode; reset forces a frozen front end with a bubble into ID/EX.
   always_comb begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      idex_noop  = 1'b0;
      ifid_flush = 1'b0;
      if (!rst_n) begin
         idex_noop  = 1'b1;
      end else if (mem_wait) begin
         idex_noop  = 1'b0;
      end else if (stall_s) begin
         idex_write = 1'b1;
         idex_noop  = 1'b1;
      end else begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         idex_write = 1'b1;
         ifid_flush = flush_s;
      end
   end

`ifdef STALL_STATS_EN
   logic [STAT_W-1:0] stall_cnt_r;
   logic [STAT_W-1:0] flush_cnt_r;

   // Saturating statistics counters; stall_s and flush_s are already masked by mem_wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {STAT_W{1'b0}};
         flush_cnt_r <= {STAT_W{1'b0}};
      end else begin
         if (stall_s && (stall_cnt_r != {STAT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (flush_s && (flush_cnt_r != {STAT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cycles = stall_cnt_r;
   assign flush_count  = flush_cnt_r;
`else
   assign stall_cycles = {STAT_W{1'b0}};
   assign flush_count  = {STAT_W{1'b0}};
`endif

endmodule : pipeline_stall_ctrl
